// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding and
// the counter-width helper.
package serial_adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   // Bits needed to count 0..v-1; never less than one.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
interface serial_adder_if #(parameter int WIDTH = 8);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;
   logic             busy;

   modport master (
      output in_valid, a, b, sub, cin, out_ready,
      input  in_ready, out_valid, sum, carry_out, overflow, busy
   );

   modport slave (
      input  in_valid, a, b, sub, cin, out_ready,
      output in_ready, out_valid, sum, carry_out, overflow, busy
   );

endinterface

// File: rtl/serial_adder_cell.sv
// One-bit full adder; the only arithmetic in the serial datapath.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles
// per operation, result held on a valid/ready output until consumed.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst_n,
   serial_adder_if.slave bus
);

   localparam int CW = clog2(WIDTH);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] acc;
   logic             cy;
   logic [WIDTH-1:0] sum_q;
   logic             co_q;
   logic             ov_q;
   logic             ov_done;
   logic             fa_s;
   logic             fa_co;

   full_adder_cell u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (cy),
      .s    (fa_s),
      .cout (fa_co)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         a_sr    <= '0;
         b_sr    <= '0;
         acc     <= '0;
         cy      <= 1'b0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
         ov_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  // Subtract is a + ~b + ~borrow, so invert b and the carry here.
                  a_sr  <= bus.a;
                  b_sr  <= bus.b ^ {WIDTH{bus.sub}};
                  cy    <= bus.sub ? ~bus.cin : bus.cin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc  <= {fa_s, acc[WIDTH-1:1]};
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               cy   <= fa_co;
               cnt  <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  // cy here is the carry into the MSB; with the carry out it
                  // gives signed overflow.
                  sum_q   <= {fa_s, acc[WIDTH-1:1]};
                  co_q    <= fa_co;
                  ov_q    <= cy ^ fa_co;
                  ov_done <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  ov_done <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = rst_n && (state == IDLE);
   assign bus.out_valid = ov_done;
   assign bus.sum       = sum_q;
   assign bus.carry_out = co_q;
   assign bus.overflow  = ov_q;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder against an integer reference model.
module tb_serial_adder;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(W)) bus ();

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic, unsigned for sum/carry and signed for overflow.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c,
                                 output logic [W-1:0] sm, output logic co, output logic ov);
      int ua, ub, sa, sb, ci, u, sv;
      ua = int'(a); ub = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      ci = int'(c);
      if (!s) begin
         u  = ua + ub + ci;
         sv = sa + sb + ci;
         co = (u >= (1 << W));
      end else begin
         u  = ua - ub - ci;
         sv = sa - sb - ci;
         co = (u >= 0);
      end
      sm = u[W-1:0];
      ov = (sv > (2 ** (W - 1)) - 1) || (sv < -(2 ** (W - 1)));
   endfunction

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c);
      bus.a = a; bus.b = b; bus.sub = s; bus.cin = c;
      bus.in_valid = 1'b1;
   endtask

   // Counts edges from now until out_valid, bounded.
   task automatic wait_result(output int k);
      k = 0;
      while (!bus.out_valid && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic c, input int hold);
      logic [W-1:0] em;
      logic eco, eov;
      int k;
      model(a, b, s, c, em, eco, eov);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      drive(a, b, s, c);
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      wait_result(k);
      chk({tag, "_latency"}, 32'(k), 32'd8);
      chk({tag, "_sum"}, 32'(bus.sum), 32'(em));
      chk({tag, "_carry"}, 32'(bus.carry_out), 32'(eco));
      chk({tag, "_ovf"}, 32'(bus.overflow), 32'(eov));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
         chk({tag, "_hold_sum"}, 32'(bus.sum), 32'(em));
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, "_ret_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_ret_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int k;
      logic [W-1:0] ra, rb;
      logic rs, rc;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_sum", 32'(bus.sum), 32'd0);
      chk("rst_carry", 32'(bus.carry_out), 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

      // Directed add/subtract cases
      run_op("add0", 8'h00, 8'h00, 1'b0, 1'b0, 0);
      run_op("addwrap", 8'hFF, 8'h01, 1'b0, 1'b0, 1);
      run_op("addovf", 8'h7F, 8'h01, 1'b0, 1'b0, 0);
      run_op("sub57", 8'h05, 8'h07, 1'b1, 1'b0, 0);
      run_op("subovf", 8'h80, 8'h01, 1'b1, 1'b0, 0);
      run_op("subbin", 8'h10, 8'h01, 1'b1, 1'b1, 0);
      run_op("addcin", 8'hA5, 8'h5A, 1'b0, 1'b1, 0);

      // Backpressure while new operands are offered
      drive(8'h40, 8'h40, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(8'h11, 8'h22, 1'b0, 1'b0);
      wait_result(k);
      chk("bp_latency", 32'(k), 32'd8);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_sum", 32'(bus.sum), 32'h80);
         chk("bp_ovf", 32'(bus.overflow), 32'd1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("bp_idle_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_idle_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("bp_accept_busy", 32'(bus.busy), 32'd1);
      wait_result(k);
      chk("bp_new_latency", 32'(k), 32'd8);
      chk("bp_new_sum", 32'(bus.sum), 32'h33);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;

      // Reset on the 3rd RUN cycle
      drive(8'hFF, 8'hFF, 1'b0, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      run_op("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 0);

      // Random back-to-back with random consumer stalls
      for (int i = 0; i < 200; i++) begin
         ra = W'($urandom); rb = W'($urandom);
         rs = 1'($urandom); rc = 1'($urandom);
         run_op("rand", ra, rb, rs, rc, int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised bit-serial adder/subtractor; successor to the single-bit half adder. It accepts two WIDTH-bit operands over a valid/ready handshake and processes one bit per clock through a single full-adder cell, LSB first. It then presents sum, carry and signed overflow on a held output handshake. It is intended as a small-area arithmetic tile for TinyTapeout-style designs, where latency is traded for gate count.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands and mode valid
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = add, 1 = subtract (A - B)
cin  input  1  carry-in for add; borrow-in for subtract
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
carry_out  output  1  carry out of MSB; for subtract, 1 = no borrow
overflow  output  1  signed two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: rst_n sampled low at a rising edge has the following effect.
  - State goes to IDLE and the bit counter goes to 0.
  - sum, carry_out, overflow and out_valid go to 0.
  - in_ready is driven 0 while rst_n is low.
  - Reset overrides every other input, including in mid-RUN and in DONE; any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid && in_ready, latch a, b, sub and the effective carry-in (sub ? ~cin : cin) into internal shift registers.
  - The B register stores b XOR {WIDTH{sub}}.
  - Clear the bit counter and go to RUN.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - Each edge feeds bit 0 of the A and B shift registers plus the carry flop into the full-adder cell.
  - The cell's sum bit is shifted into the result MSB (shift-right accumulate); the carry flop takes the cell's carry.
  - Counter increments by 1.
  - On the edge where the counter equals WIDTH-1:
    - capture the carry into the MSB position as msb_cin;
    - go to DONE.
- Latency: out_valid rises exactly WIDTH rising edges after the accepting edge.
- DONE:
  - out_valid = 1; sum = accumulated result; carry_out = carry flop; overflow = msb_cin XOR carry_out.
  - All outputs are held stable while out_ready = 0, for unbounded backpressure.
  - On an edge with out_valid && out_ready, go to IDLE and clear out_valid. in_ready is 1 in the following cycle.
  - No overlap between operations: maximum throughput is one operation per WIDTH+2 cycles.
- Arithmetic:
  - Add: result = a + b + cin (mod 2^WIDTH).
  - Subtract: result = a + ~b + ~cin, i.e. a - b - cin.
- sum, carry_out and overflow update only on entry to DONE. Outside DONE they hold their last value; only out_valid qualifies them.
- busy = (state != IDLE).

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encoding localparams ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - a counter-width function clog2(WIDTH).
- One natural sub-module: full_adder_cell, purely combinational, with inputs a, b, cin and outputs s, cout. It is instantiated once and is the direct generalisation of the half adder.

Test Plan (WIDTH = 8):
1. Add: a=0x00, b=0x00, cin=0 -> sum=0x00, carry_out=0, overflow=0; out_valid exactly 8 edges after accept.
2. Add: a=0xFF, b=0x01, cin=0 -> sum=0x00, carry_out=1, overflow=0. Then a=0x7F, b=0x01 -> sum=0x80, carry_out=0, overflow=1.
3. Subtract:
   - a=0x05, b=0x07, cin=0 -> sum=0xFE, carry_out=0, overflow=0;
   - a=0x80, b=0x01, cin=0 -> sum=0x7F, carry_out=1, overflow=1;
   - a=0x10, b=0x01, cin=1 -> sum=0x0E, carry_out=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> outputs unchanged, in_ready=0, new operands not accepted. Raise out_ready -> IDLE next cycle and the new operation is accepted.
5. Reset mid-operation: assert rst_n=0 on the 3rd RUN cycle -> out_valid=0 and busy=0 after the edge. After release, in_ready=1, and a=0x12, b=0x34 add produces sum=0x46.
6. Randomised back-to-back: 200 random a, b, sub, cin with random out_ready -> every result matches the reference model, and each accept-to-out_valid interval is 8 cycles.
